// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: writes one colour into an axis-aligned rectangle of the
// framebuffer RAM, one pixel per cycle in row-major order, via a start/busy/done handshake.
// Optional feature macro: RECT_OUTLINE_EN adds an `outline_i` input that restricts writes
// to the rectangle border while keeping the same walk and cycle count.
module rect_fill_engine #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FB_W_LOG2  = 4
) (
  input  logic                              clk_i,
  input  logic                              reset_ni,
  input  logic                              start_i,
  input  logic [FB_W_LOG2-1:0]              x0_i,
  input  logic [FB_W_LOG2-1:0]              x1_i,
  input  logic [ADDR_WIDTH-FB_W_LOG2-1:0]   y0_i,
  input  logic [ADDR_WIDTH-FB_W_LOG2-1:0]   y1_i,
  input  logic [DATA_WIDTH-1:0]             color_i,
`ifdef RECT_OUTLINE_EN
  input  logic                              outline_i,
`endif
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              we_o,
  output logic [ADDR_WIDTH-1:0]             wr_addr_o,
  output logic [DATA_WIDTH-1:0]             wr_data_o
);

  localparam int unsigned FB_H_LOG2 = ADDR_WIDTH - FB_W_LOG2;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StFill,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [FB_W_LOG2-1:0]   xl_q, xl_d, xh_q, xh_d, cx_q, cx_d;
  logic [FB_H_LOG2-1:0]   yl_q, yl_d, yh_q, yh_d, cy_q, cy_d;
  logic [DATA_WIDTH-1:0]  color_q, color_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
`ifdef RECT_OUTLINE_EN
  logic                   outline_q, outline_d;
`endif

  // Position presented to the RAM in the coming FILL cycle.
  logic [FB_W_LOG2-1:0]   pos_x;
  logic [FB_H_LOG2-1:0]   pos_y;
  logic                   pos_we;
  logic                   last_pos;

  // Next walk position: the top-left corner out of SETUP, else the row-major successor.
  always_comb begin
    pos_x = cx_q;
    pos_y = cy_q;
    if (state_q == StSetup) begin
      pos_x = xl_q;
      pos_y = yl_q;
    end else if (cx_q == xh_q) begin
      pos_x = xl_q;
      pos_y = cy_q + FB_H_LOG2'(1);
    end else begin
      pos_x = cx_q + FB_W_LOG2'(1);
    end
  end

  assign last_pos = (cx_q == xh_q) && (cy_q == yh_q);

`ifdef RECT_OUTLINE_EN
  // Interior positions are walked but not written when outlining.
  assign pos_we = !outline_q || (pos_x == xl_q) || (pos_x == xh_q) ||
                  (pos_y == yl_q) || (pos_y == yh_q);
`else
  assign pos_we = 1'b1;
`endif

  // Next-state logic; all outputs are computed one cycle early so they leave flops.
  always_comb begin
    state_d   = state_q;
    xl_d      = xl_q;
    xh_d      = xh_q;
    yl_d      = yl_q;
    yh_d      = yh_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    color_d   = color_q;
    we_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef RECT_OUTLINE_EN
    outline_d = outline_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StSetup;
          xl_d    = (x0_i <= x1_i) ? x0_i : x1_i;
          xh_d    = (x0_i <= x1_i) ? x1_i : x0_i;
          yl_d    = (y0_i <= y1_i) ? y0_i : y1_i;
          yh_d    = (y0_i <= y1_i) ? y1_i : y0_i;
          color_d = color_i;
`ifdef RECT_OUTLINE_EN
          outline_d = outline_i;
`endif
        end
      end
      StSetup: begin
        state_d   = StFill;
        cx_d      = pos_x;
        cy_d      = pos_y;
        we_d      = pos_we;
        wr_addr_d = {pos_y, pos_x};
        wr_data_d = color_q;
      end
      StFill: begin
        if (last_pos) begin
          state_d = StDone;
        end else begin
          cx_d      = pos_x;
          cy_d      = pos_y;
          we_d      = pos_we;
          wr_addr_d = {pos_y, pos_x};
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  // State and output registers; reset leaves the RAM port idle at address 0.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= StIdle;
      xl_q      <= '0;
      xh_q      <= '0;
      yl_q      <= '0;
      yh_q      <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      color_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef RECT_OUTLINE_EN
      outline_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      xl_q      <= xl_d;
      xh_q      <= xh_d;
      yl_q      <= yl_d;
      yh_q      <= yh_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      color_q   <= color_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      we_q      <= we_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef RECT_OUTLINE_EN
      outline_q <= outline_d;
`endif
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign we_o      = we_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: table vectors, hand-written corner sequences and random
// rectangles, all checked cycle by cycle against a rectangle-walk model and a RAM image.
module tb_rect_fill_engine;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int WL = 4;
  localparam int HL = AW - WL;
  localparam int NPIX = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [WL-1:0] x0, x1;
  logic [HL-1:0] y0, y1;
  logic [DW-1:0] color;
`ifdef RECT_OUTLINE_EN
  logic          outline;
`endif
  logic          busy, done, we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          clr;
  logic [DW-1:0] mem     [NPIX];
  logic [DW-1:0] exp_mem [NPIX];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rect_fill_engine #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FB_W_LOG2  (WL)
  ) dut (
    .clk_i     (clk),
    .reset_ni  (reset_n),
    .start_i   (start),
    .x0_i      (x0),
    .x1_i      (x1),
    .y0_i      (y0),
    .y1_i      (y1),
    .color_i   (color),
`ifdef RECT_OUTLINE_EN
    .outline_i (outline),
`endif
    .busy_o    (busy),
    .done_o    (done),
    .we_o      (we),
    .wr_addr_o (wr_addr),
    .wr_data_o (wr_data)
  );

  // Framebuffer RAM with synchronous write.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NPIX; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_mem(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (mem[i] !== exp_mem[i]) bad++;
    chk(nm, bad, 0);
  endtask

  // mode: 0 normal, 1 extra start with other coords while busy,
  //       2 raise start again during done (left high), 3 start already high on entry.
  // abort_k > 0 asserts reset at that sample point.
  task automatic run_cmd(input int ax0, input int ax1, input int ay0, input int ay1,
                         input logic [DW-1:0] col, input bit ol, input int mode,
                         input int abort_k, output int nw, output int first_a,
                         output int last_a);
    int xl, xh, yl, yh, n, j;
    int   addr_q[$];
    bit   wen_q[$];
    xl = (ax0 < ax1) ? ax0 : ax1;
    xh = (ax0 < ax1) ? ax1 : ax0;
    yl = (ay0 < ay1) ? ay0 : ay1;
    yh = (ay0 < ay1) ? ay1 : ay0;
    for (int y = yl; y <= yh; y++) begin
      for (int x = xl; x <= xh; x++) begin
        addr_q.push_back(y * (1 << WL) + x);
        wen_q.push_back(!ol || x == xl || x == xh || y == yl || y == yh);
      end
    end
    n = addr_q.size();
    nw = 0;
    first_a = -1;
    last_a = -1;
    if (mode != 3) begin
      @(negedge clk);
      x0 = WL'(ax0); x1 = WL'(ax1); y0 = HL'(ay0); y1 = HL'(ay1); color = col;
`ifdef RECT_OUTLINE_EN
      outline = ol;
`endif
      start = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    // Scrambled inputs after acceptance must not matter.
    start = 1'b0;
    x0 = ~WL'(ax0); x1 = ~WL'(ax1); y0 = ~HL'(ay0); y1 = ~HL'(ay1); color = ~col;
`ifdef RECT_OUTLINE_EN
    outline = ~ol;
`endif
    for (int k = 1; k <= n + 3; k++) begin
      if (k > 1) @(negedge clk);
      if (k == abort_k) begin
        reset_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_we", we, 0);
        chk("abort_addr", wr_addr, 0);
        chk("abort_data", wr_data, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      if (we) begin
        nw++;
        if (first_a < 0) first_a = int'(wr_addr);
        last_a = int'(wr_addr);
      end
      if (k == 1) begin
        chk("setup_busy", busy, 1);
        chk("setup_we", we, 0);
        chk("setup_done", done, 0);
      end else if (k <= n + 1) begin
        j = k - 2;
        chk("fill_busy", busy, 1);
        chk("fill_done", done, 0);
        chk("fill_we", we, wen_q[j]);
        if (wen_q[j]) begin
          chk("fill_addr", wr_addr, addr_q[j]);
          chk("fill_data", wr_data, col);
          exp_mem[addr_q[j]] = col;
        end
      end else if (k == n + 2) begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_we", we, 0);
        if (mode == 2) begin
          x0 = WL'(ax0); x1 = WL'(ax1); y0 = HL'(ay0); y1 = HL'(ay1); color = col;
`ifdef RECT_OUTLINE_EN
          outline = ol;
`endif
          start = 1'b1;
        end
      end else begin
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_we", we, 0);
      end
      if (mode == 1 && k == 3) begin
        x0 = 4'd12; x1 = 4'd15; y0 = 4'd13; y1 = 4'd15; color = 32'h0BAD_0BAD;
        start = 1'b1;
      end
      if (mode == 1 && k == 4) start = 1'b0;
    end
  endtask

  typedef struct {
    int            x0, x1, y0, y1;
    logic [DW-1:0] col;
    int            exp_n, exp_first, exp_last;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int nw, fa, la, n_exp, rx0, rx1, ry0, ry1;
    bit rol;
    logic [DW-1:0] rcol;

    vecs[0] = '{2, 4, 3, 4, 32'hDEAD_BEEF, 6, 50, 68};
    vecs[1] = '{4, 2, 4, 3, 32'hCAFE_F00D, 6, 50, 68};
    vecs[2] = '{7, 7, 9, 9, 32'h1234_5678, 1, 151, 151};
    vecs[3] = '{0, 15, 0, 15, 32'hA5A5_0F0F, 256, 0, 255};

    for (int i = 0; i < NPIX; i++) exp_mem[i] = '0;
    reset_n = 1'b0;
    start = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
`ifdef RECT_OUTLINE_EN
    outline = 1'b0;
`endif
    clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", we, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    clr = 1'b0;
    reset_n = 1'b1;

    // Table vectors: write count and first/last address observed on the port.
    for (int v = 0; v < 4; v++) begin
      run_cmd(vecs[v].x0, vecs[v].x1, vecs[v].y0, vecs[v].y1, vecs[v].col, 1'b0, 0, 0,
              nw, fa, la);
      chk("tbl_nwrites", nw, vecs[v].exp_n);
      chk("tbl_first", fa, vecs[v].exp_first);
      chk("tbl_last", la, vecs[v].exp_last);
      check_mem("tbl_ram");
    end

    // Reset in the middle of a full-screen fill leaves a partial rectangle.
    run_cmd(0, 15, 0, 15, 32'h7777_1111, 1'b0, 0, 20, nw, fa, la);
    check_mem("abort_ram");

    // Start pulsed while busy is ignored.
    run_cmd(1, 5, 2, 6, 32'h5555_AAAA, 1'b0, 1, 0, nw, fa, la);
    chk("busy_start_nw", nw, 25);
    check_mem("busy_start_ram");

    // Start raised during done is accepted on the following cycle.
    run_cmd(3, 6, 10, 12, 32'h0101_0202, 1'b0, 2, 0, nw, fa, la);
    run_cmd(3, 6, 10, 12, 32'h0101_0202, 1'b0, 3, 0, nw, fa, la);
    chk("held_start_nw", nw, 12);
    start = 1'b0;
    check_mem("held_start_ram");

`ifdef RECT_OUTLINE_EN
    run_cmd(0, 4, 0, 4, 32'h1111_1111, 1'b0, 0, 0, nw, fa, la);
    run_cmd(1, 3, 1, 3, 32'h2222_2222, 1'b1, 0, 0, nw, fa, la);
    chk("outline_nw", nw, 8);
    check_mem("outline_ram");
`endif

    // Random rectangles against the walk model.
    for (int r = 0; r < 25; r++) begin
      rx0 = $urandom_range(0, 15);
      rx1 = $urandom_range(0, 15);
      ry0 = $urandom_range(0, 15);
      ry1 = $urandom_range(0, 15);
      rcol = $urandom;
      rol = 1'b0;
`ifdef RECT_OUTLINE_EN
      rol = 1'($urandom_range(0, 1));
`endif
      n_exp = 0;
      for (int y = 0; y < 16; y++) begin
        for (int x = 0; x < 16; x++) begin
          if (x >= (rx0 < rx1 ? rx0 : rx1) && x <= (rx0 < rx1 ? rx1 : rx0) &&
              y >= (ry0 < ry1 ? ry0 : ry1) && y <= (ry0 < ry1 ? ry1 : ry0) &&
              (!rol || x == rx0 || x == rx1 || y == ry0 || y == ry1)) n_exp++;
        end
      end
      run_cmd(rx0, rx1, ry0, ry1, rcol, rol, 0, 0, nw, fa, la);
      chk("rand_nw", nw, n_exp);
      check_mem("rand_ram");
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
